// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, default timings,
// and the write-engine state type.
package sdram_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_COL_MAX   = 512;
    localparam int DEF_ROW_MAX   = 4096;
    localparam int DEF_T_RCD     = 2;
    localparam int DEF_T_WR      = 2;
    localparam int DEF_T_RP      = 2;

    // A10 high selects all banks for PRECHARGE
    localparam logic [11:0] ADDR_PRE_ALL = 12'h400;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_REQ,
        WR_ACT,
        WR_WRITE,
        WR_PRE,
        WR_REL
    } wr_state_e;

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// Row/column/word counters for the SDRAM write engine.
// Addresses persist across jobs; only the word count reloads.
module sdram_wr_addr_gen
    import sdram_pkg::*;
#(
    parameter int WR_WORDS  = 256,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int COL_MAX   = DEF_COL_MAX,
    parameter int ROW_MAX   = DEF_ROW_MAX,
    parameter int COL_W     = $clog2(COL_MAX),
    parameter int CNT_W     = $clog2(WR_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_load,
    input  logic             burst_done,
    output logic [11:0]      row,
    output logic [COL_W-1:0] col,
    output logic             row_end,
    output logic             last_burst,
    output logic             job_done
);

    logic [11:0]      row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign row        = row_q;
    assign col        = col_q;
    assign row_end    = (col_q == COL_W'(COL_MAX - BURST_LEN));
    assign last_burst = (cnt_q == CNT_W'(BURST_LEN));
    assign job_done   = (cnt_q == '0);

    // Advance address and word count at each completed burst
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cnt_d = cnt_q;
        if (job_load) begin
            cnt_d = CNT_W'(WR_WORDS);
        end else if (burst_done) begin
            cnt_d = cnt_q - CNT_W'(BURST_LEN);
            if (row_end) begin
                col_d = '0;
                row_d = (row_q == 12'(ROW_MAX - 1)) ? '0 : row_q + 12'd1;
            end else begin
                col_d = col_q + COL_W'(BURST_LEN);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            cnt_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_write.sv
// SDRAM write engine: drains WR_WORDS FIFO words per trigger as
// back-to-back bursts, yielding the bus at refresh and row change.
module sdram_write
    import sdram_pkg::*;
#(
    parameter int WR_WORDS  = 256,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int COL_MAX   = DEF_COL_MAX,
    parameter int ROW_MAX   = DEF_ROW_MAX,
    parameter int T_RCD     = DEF_T_RCD,
    parameter int T_WR      = DEF_T_WR,
    parameter int T_RP      = DEF_T_RP,
    parameter int HOLDOFF   = 4
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        wr_trig,
    input  logic        wr_en,
    input  logic        ref_req,
    output logic        wr_req,
    output logic        wr_end,
    output logic        flag_wr,
    output logic [3:0]  wr_cmd,
    output logic [11:0] wr_addr,
    output logic [1:0]  wr_bank_addr,
    output logic        wfifo_rd_en,
    input  logic [15:0] wfifo_rd_data,
    output logic [15:0] wr_data
);

    localparam int COL_W = $clog2(COL_MAX);
    localparam int BW    = $clog2(BURST_LEN);
    localparam int TW    = 8;
    localparam int HW    = $clog2(HOLDOFF + 1);

    wr_state_e        state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             flag_q, flag_d;

    logic             job_load;
    logic             burst_done;
    logic [11:0]      row;
    logic [COL_W-1:0] col;
    logic             row_end;
    logic             last_burst;
    logic             job_done;
    logic             last_beat;
    logic             leave_wr;

    assign wr_data      = wfifo_rd_data;
    assign wr_bank_addr = 2'b00;
    assign flag_wr      = flag_q;
    assign last_beat    = (beat_q == BW'(BURST_LEN - 1));
    assign leave_wr     = last_burst | row_end | ref_req;

    sdram_wr_addr_gen #(
        .WR_WORDS  (WR_WORDS),
        .BURST_LEN (BURST_LEN),
        .COL_MAX   (COL_MAX),
        .ROW_MAX   (ROW_MAX)
    ) u_addr (
        .clk        (sclk),
        .rst_n      (s_rst_n),
        .job_load   (job_load),
        .burst_done (burst_done),
        .row        (row),
        .col        (col),
        .row_end    (row_end),
        .last_burst (last_burst),
        .job_done   (job_done)
    );

    // Next-state and command decode
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        beat_d      = beat_q;
        flag_d      = flag_q;
        hold_d      = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
        job_load    = 1'b0;
        burst_done  = 1'b0;
        wr_req      = 1'b0;
        wr_end      = 1'b0;
        wr_cmd      = CMD_NOP;
        wr_addr     = '0;
        wfifo_rd_en = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (wr_trig && hold_q == '0) begin
                    flag_d   = 1'b1;
                    job_load = 1'b1;
                    state_d  = WR_REQ;
                end
            end
            WR_REQ: begin
                wr_req = 1'b1;
                if (wr_en) begin
                    tmr_d   = '0;
                    state_d = WR_ACT;
                end
            end
            WR_ACT: begin
                if (tmr_q == '0) begin
                    wr_cmd  = CMD_ACT;
                    wr_addr = row;
                end
                // prefetch so the first beat lands with WRITE
                if (tmr_q == TW'(T_RCD - 1)) begin
                    wfifo_rd_en = 1'b1;
                    beat_d      = '0;
                    state_d     = WR_WRITE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            WR_WRITE: begin
                if (beat_q == '0) begin
                    wr_cmd  = CMD_WRITE;
                    wr_addr = 12'(col);
                end
                wfifo_rd_en = !(last_beat && leave_wr);
                beat_d      = last_beat ? '0 : beat_q + BW'(1);
                if (last_beat) begin
                    burst_done = 1'b1;
                    if (leave_wr) begin
                        tmr_d   = '0;
                        state_d = WR_PRE;
                    end
                end
            end
            WR_PRE: begin
                if (tmr_q == TW'(T_WR)) begin
                    wr_cmd  = CMD_PRE;
                    wr_addr = ADDR_PRE_ALL;
                end
                if (tmr_q == TW'(T_WR + T_RP)) begin
                    state_d = WR_REL;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            WR_REL: begin
                wr_end = 1'b1;
                if (job_done) begin
                    flag_d  = 1'b0;
                    hold_d  = HW'(HOLDOFF);
                    state_d = WR_IDLE;
                end else begin
                    state_d = WR_REQ;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q <= WR_IDLE;
            tmr_q   <= '0;
            beat_q  <= '0;
            hold_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
            flag_q  <= flag_d;
        end
    end

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write with a counting FIFO model.
// Small ROW_MAX keeps the row-wrap case within a few jobs.
`timescale 1ns/1ps
module tb_sdram_write;
    import sdram_pkg::*;

    localparam int ROWS    = 4;
    localparam int WORDS   = 256;
    localparam int BL      = 4;
    localparam int COLS    = 512;
    localparam int T_RCD   = 2;
    localparam int T_WR    = 2;
    localparam int T_RP    = 2;
    localparam int HOLDOFF = 4;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        wr_trig = 1'b0;
    logic        wr_en = 1'b0;
    logic        ref_req = 1'b0;
    logic        wr_req;
    logic        wr_end;
    logic        flag_wr;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank_addr;
    logic        wfifo_rd_en;
    logic [15:0] wfifo_rd_data = '0;
    logic [15:0] wr_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rptr = 0;

    int n_rd = 0, n_wr = 0, n_end = 0;
    int exp_row = 0, exp_col = 0, exp_data = 0;
    int beats_left = 0;
    int t_act = 0, t_pre = 0, last_b = 0;
    bit first_wr = 0;
    int last_wr_addr = 0, last_act_addr = 0;

    sdram_write #(
        .WR_WORDS (WORDS),
        .BURST_LEN(BL),
        .COL_MAX  (COLS),
        .ROW_MAX  (ROWS),
        .T_RCD    (T_RCD),
        .T_WR     (T_WR),
        .T_RP     (T_RP),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .sclk         (sclk),
        .s_rst_n      (s_rst_n),
        .wr_trig      (wr_trig),
        .wr_en        (wr_en),
        .ref_req      (ref_req),
        .wr_req       (wr_req),
        .wr_end       (wr_end),
        .flag_wr      (flag_wr),
        .wr_cmd       (wr_cmd),
        .wr_addr      (wr_addr),
        .wr_bank_addr (wr_bank_addr),
        .wfifo_rd_en  (wfifo_rd_en),
        .wfifo_rd_data(wfifo_rd_data),
        .wr_data      (wr_data)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    // FIFO holds 0,1,2,... ; dout valid the cycle after rd_en
    always @(posedge sclk) begin
        if (wfifo_rd_en) begin
            wfifo_rd_data <= rptr[15:0];
            rptr <= rptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge sclk);
            if (s_rst_n) begin
                if (wfifo_rd_en) n_rd++;
                if (wr_cmd == CMD_ACT) begin
                    chk("act_row", 32'(wr_addr), exp_row);
                    last_act_addr = wr_addr;
                    t_act = cyc;
                    first_wr = 1;
                end
                if (wr_cmd == CMD_WRITE) begin
                    if (first_wr) chk("t_rcd", cyc - t_act, T_RCD);
                    first_wr = 0;
                    chk("burst_gap", beats_left, 0);
                    chk("wr_col", 32'(wr_addr), exp_col);
                    last_wr_addr = wr_addr;
                    n_wr++;
                    if (exp_col == COLS - BL) begin
                        exp_col = 0;
                        exp_row = (exp_row + 1) % ROWS;
                    end else begin
                        exp_col += BL;
                    end
                    beats_left = BL;
                end
                if (beats_left > 0) begin
                    chk("dq", 32'(wr_data), exp_data & 16'hffff);
                    exp_data++;
                    beats_left--;
                    if (beats_left == 0) last_b = cyc;
                end
                if (wr_cmd == CMD_PRE) begin
                    chk("pre_addr", 32'(wr_addr), 12'h400);
                    chk("t_wr", cyc - last_b, T_WR + 1);
                    t_pre = cyc;
                end
                if (wr_end) begin
                    chk("t_rp", cyc - t_pre, T_RP + 1);
                    n_end++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!wr_req && k < 100) begin
            step();
            k++;
        end
        chk("req_seen", wr_req, 1);
    endtask

    task automatic grant();
        repeat (3) step();
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!wr_end && k < 3000) begin
            step();
            k++;
        end
        chk("end_seen", wr_end, 1);
    endtask

    task automatic wait_writes(input int base, input int n);
        int k = 0;
        while (n_wr - base < n && k < 2000) begin
            step();
            k++;
        end
        chk("writes_seen", n_wr - base, n);
    endtask

    task automatic do_job(input bit preempt, input int resume_col,
                          input bit trig_after);
        int rd0, end0, wr0;
        rd0 = n_rd;
        end0 = n_end;
        wr0 = n_wr;
        wr_trig = 1'b1;
        wait_req();
        wr_trig = 1'b0;
        grant();
        if (preempt) begin
            wait_writes(wr0, 11);
            ref_req = 1'b1;
            wait_end();
            ref_req = 1'b0;
            chk("flag_mid", flag_wr, 1);
            step();
            chk("req_again", wr_req, 1);
            grant();
            wait_writes(wr0, 12);
            chk("resume_col", last_wr_addr, resume_col);
        end
        wait_end();
        wr_trig = trig_after;
        step();
        chk("flag_fall", flag_wr, 0);
        chk("rd_cnt", n_rd - rd0, WORDS);
        chk("end_cnt", n_end - end0, preempt ? 2 : 1);
    endtask

    initial begin
        int k;
        int seen;
        int wr0;
        fork
            monitor();
        join_none

        repeat (3) step();
        chk("rst_req", wr_req, 0);
        chk("rst_end", wr_end, 0);
        chk("rst_flag", flag_wr, 0);
        chk("rst_rd", wfifo_rd_en, 0);
        chk("rst_cmd", 32'(wr_cmd), 4'b0111);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_bank", 32'(wr_bank_addr), 0);
        s_rst_n = 1'b1;
        step();

        do_job(0, 0, 0);
        do_job(0, 0, 0);
        do_job(1, 44, 1);

        repeat (3) step();
        wr_trig = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (wr_req) seen++;
        end
        chk("holdoff_quiet", seen, 0);

        do_job(0, 0, 1);
        k = 0;
        while (!wr_req && k < 50) begin
            step();
            k++;
        end
        chk("holdoff_len", k, HOLDOFF + 1);

        do_job(0, 0, 0);
        do_job(0, 0, 0);
        do_job(0, 0, 0);
        do_job(0, 0, 0);

        wr0 = n_wr;
        wr_trig = 1'b1;
        wait_req();
        wr_trig = 1'b0;
        grant();
        wait_writes(wr0, 1);
        chk("wrap_act", last_act_addr, 0);
        chk("wrap_col", last_wr_addr, 0);
        k = 0;
        while (wr_cmd != CMD_WRITE && k < 20) begin
            step();
            k++;
        end
        chk("pre_rst_cmd", 32'(wr_cmd), 32'(CMD_WRITE));
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("arst_cmd", 32'(wr_cmd), 32'(CMD_NOP));
        chk("arst_rd", wfifo_rd_en, 0);
        chk("arst_flag", flag_wr, 0);
        chk("arst_addr", 32'(wr_addr), 0);
        step();
        s_rst_n = 1'b1;
        exp_row = 0;
        exp_col = 0;
        beats_left = 0;
        exp_data = rptr;
        step();

        do_job(0, 0, 0);
        chk("post_rst_act", last_act_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
